// File: rtl/icache_refill_ctrl.sv
// Instruction-cache line refill controller: gathers an L2 burst into a local line buffer,
// then replays it to the cache set as an unbroken NB-cycle replacement stream.
module icache_refill_ctrl #(
  parameter int unsigned B      = 64,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ic_miss_i,
  input  logic [ADDR_W-1:0] miss_addr_i,
  input  logic              flush_i,
  output logic              l2_req_o,
  output logic [ADDR_W-1:0] l2_addr_o,
  input  logic              l2_valid_i,
  input  logic [63:0]       l2_data_i,
  output logic              ic_repl_grant_o,
  output logic [63:0]       rep_word_o,
  output logic              busy_o
);

  localparam int unsigned       NB       = B / 8;
  localparam int unsigned       CntW     = $clog2(NB);
  localparam logic [CntW-1:0]   LastBeat = CntW'(NB - 1);
  localparam logic [ADDR_W-1:0] OffMask  = ADDR_W'(B - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StStream,
    StDrain,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] line_addr_q, line_addr_d;
  logic [CntW-1:0]   fill_cnt_q, fill_cnt_d;
  logic [CntW-1:0]   stream_idx_q, stream_idx_d;
  logic              buf_we;
  logic [63:0]       line_buf_q [NB];

  logic              l2_req_q;
  logic [ADDR_W-1:0] l2_addr_q;
  logic              grant_q;
  logic              busy_q;

  always_comb begin
    state_d      = state_q;
    line_addr_d  = line_addr_q;
    fill_cnt_d   = fill_cnt_q;
    stream_idx_d = stream_idx_q;
    buf_we       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ic_miss_i && !flush_i) begin
          state_d     = StFetch;
          line_addr_d = miss_addr_i & ~OffMask;
          fill_cnt_d  = '0;
        end
      end
      StFetch: begin
        if (l2_valid_i) begin
          buf_we     = 1'b1;
          fill_cnt_d = fill_cnt_q + 1'b1;
        end
        if (l2_valid_i && fill_cnt_q == LastBeat) begin
          // A flush landing on the final beat drops the line without granting.
          fill_cnt_d   = '0;
          stream_idx_d = '0;
          state_d      = flush_i ? StIdle : StStream;
        end else if (flush_i) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Burst must run to completion on L2 side; beats are counted, not stored.
        if (l2_valid_i) begin
          if (fill_cnt_q == LastBeat) begin
            fill_cnt_d = '0;
            state_d    = StIdle;
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end
      end
      StStream: begin
        stream_idx_d = stream_idx_q + 1'b1;
        if (stream_idx_q == LastBeat) begin
          stream_idx_d = '0;
          state_d      = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      line_addr_q  <= '0;
      fill_cnt_q   <= '0;
      stream_idx_q <= '0;
      l2_req_q     <= 1'b0;
      l2_addr_q    <= '0;
      grant_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_addr_q  <= line_addr_d;
      fill_cnt_q   <= fill_cnt_d;
      stream_idx_q <= stream_idx_d;
      // Outputs are registered off the next state so they line up with state_q.
      l2_req_q     <= (state_d == StFetch) || (state_d == StDrain);
      l2_addr_q    <= ((state_d == StFetch) || (state_d == StDrain)) ? line_addr_d : '0;
      grant_q      <= (state_d == StStream);
      busy_q       <= (state_d != StIdle);
    end
  end

  always_ff @(posedge clk_i) begin
    if (buf_we) begin
      line_buf_q[fill_cnt_q] <= l2_data_i;
    end
  end

  always_comb begin
    rep_word_o = '0;
    if (grant_q) begin
      rep_word_o = line_buf_q[stream_idx_q];
    end
  end

  assign l2_req_o        = l2_req_q;
  assign l2_addr_o       = l2_addr_q;
  assign ic_repl_grant_o = grant_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scenario bench for icache_refill_ctrl: an L2 responder feeds bursts, the expected
// replacement stream is the sent beats in order, NB cycles, aligned address.
module tb_icache_refill_ctrl;

  localparam int B      = 64;
  localparam int NB     = B / 8;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              reset;
  logic              ic_miss;
  logic [ADDR_W-1:0] miss_addr;
  logic              flush;
  logic              l2_valid;
  logic [63:0]       l2_data;
  logic              l2_req;
  logic [ADDR_W-1:0] l2_addr;
  logic              grant;
  logic [63:0]       rep_word;
  logic              busy;

  int n_cmp = 0;
  int n_fail = 0;

  // Observations from the most recent run_refill.
  logic [63:0] sent_q[$];
  logic [63:0] got_q[$];
  logic [31:0] obs_addr;
  int          obs_grant, obs_busy_tail, obs_beats, obs_req_extra, obs_rep_leak;
  int          obs_first_beat, obs_last_beat, obs_grant_start;
  bit          obs_contig, obs_timeout, obs_reset_hit;
  logic        obs_post_grant, obs_post_req, obs_post_busy;

  icache_refill_ctrl #(.B(B), .ADDR_W(ADDR_W)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .ic_miss_i      (ic_miss),
    .miss_addr_i    (miss_addr),
    .flush_i        (flush),
    .l2_req_o       (l2_req),
    .l2_addr_o      (l2_addr),
    .l2_valid_i     (l2_valid),
    .l2_data_i      (l2_data),
    .ic_repl_grant_o(grant),
    .rep_word_o     (rep_word),
    .busy_o         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issues one miss and plays the L2 side until the block returns to idle.
  // All sampling and driving happens at the falling edge.
  task automatic run_refill(input logic [31:0] addr, input int gap, input bit rand_gap,
                            input bit fixed_data, input int flush_with_beat,
                            input bit flush_stream, input int reset_at, input bit keep_miss);
    int   gap_cnt;
    bit   seen_busy, grant_seen, grant_done, addr_seen;
    int   last_grant_cyc;
    logic [63:0] beat;
    sent_q.delete();
    got_q.delete();
    obs_addr = '0; obs_grant = 0; obs_contig = 1'b1; obs_busy_tail = -1; obs_beats = 0;
    obs_req_extra = 0; obs_rep_leak = 0; obs_timeout = 1'b0; obs_reset_hit = 1'b0;
    obs_first_beat = -1; obs_last_beat = -1; obs_grant_start = -1;
    gap_cnt = 0; seen_busy = 0; grant_seen = 0; grant_done = 0; addr_seen = 0;
    last_grant_cyc = 0;
    ic_miss = 1'b1;
    miss_addr = addr;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (!keep_miss) ic_miss = 1'b0;
      if (reset) begin
        obs_post_grant = grant; obs_post_req = l2_req; obs_post_busy = busy;
        obs_reset_hit = 1'b1;
        reset = 1'b0; l2_valid = 1'b0; flush = 1'b0;
        return;
      end
      if (busy) seen_busy = 1;
      if (l2_req) begin
        if (!addr_seen) begin obs_addr = l2_addr; addr_seen = 1; end
        if (obs_beats == NB) obs_req_extra++;
      end
      if (grant) begin
        if (grant_done) obs_contig = 1'b0;
        if (!grant_seen) obs_grant_start = cyc;
        got_q.push_back(rep_word);
        obs_grant++;
        grant_seen = 1;
        last_grant_cyc = cyc;
      end else begin
        if (grant_seen) grant_done = 1;
        if (rep_word !== 64'd0) obs_rep_leak++;
      end
      if (seen_busy && !busy) begin
        if (grant_seen) obs_busy_tail = cyc - last_grant_cyc;
        l2_valid = 1'b0;
        flush = 1'b0;
        return;
      end
      l2_valid = 1'b0;
      flush = 1'b0;
      if (l2_req && obs_beats < NB) begin
        if (gap_cnt == 0) begin
          beat = fixed_data ? (64'h1111_0000_0000_0000 | 64'(obs_beats)) : {$urandom(), $urandom()};
          if (obs_beats == flush_with_beat) flush = 1'b1;
          l2_valid = 1'b1;
          l2_data = beat;
          sent_q.push_back(beat);
          if (obs_first_beat < 0) obs_first_beat = cyc;
          obs_last_beat = cyc;
          obs_beats++;
          gap_cnt = rand_gap ? int'($urandom_range(0, 3)) : gap;
        end else begin
          gap_cnt--;
        end
      end
      if (flush_stream && grant) flush = 1'b1;
      if (reset_at >= 0 && grant && (obs_grant - 1) == reset_at) reset = 1'b1;
    end
    obs_timeout = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1; ic_miss = 1'b0; flush = 1'b0; l2_valid = 1'b0; l2_data = '0; miss_addr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ic_miss = 1'b1; miss_addr = 32'h0000_1234; l2_valid = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (l2_req !== 1'b0) begin n_fail++; $display("FAIL reset_l2_req: got %b want 0", l2_req); end
    n_cmp++; if (l2_addr !== '0) begin n_fail++; $display("FAIL reset_l2_addr: got %h want 0", l2_addr); end
    n_cmp++; if (grant !== 1'b0) begin n_fail++; $display("FAIL reset_grant: got %b want 0", grant); end
    n_cmp++; if (rep_word !== '0) begin n_fail++; $display("FAIL reset_rep_word: got %h want 0", rep_word); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0; ic_miss = 1'b0; l2_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_no_stall();
    logic [63:0] w;
    run_refill(32'h0000_1234, 0, 0, 1, -1, 0, -1, 0);
    n_cmp++; if (obs_timeout) begin n_fail++; $display("FAIL nostall_timeout: got 1 want 0"); end
    n_cmp++; if (obs_addr !== 32'h0000_1200) begin n_fail++; $display("FAIL nostall_addr: got %h want 00001200", obs_addr); end
    n_cmp++; if (obs_grant !== NB) begin n_fail++; $display("FAIL nostall_grant_len: got %0d want %0d", obs_grant, NB); end
    n_cmp++; if (!obs_contig) begin n_fail++; $display("FAIL nostall_contig: got 0 want 1"); end
    n_cmp++; if (obs_last_beat - obs_first_beat + 1 !== NB) begin n_fail++; $display("FAIL nostall_fill_span: got %0d want %0d", obs_last_beat - obs_first_beat + 1, NB); end
    n_cmp++; if (obs_grant_start - obs_last_beat !== 1) begin n_fail++; $display("FAIL nostall_grant_lat: got %0d want 1", obs_grant_start - obs_last_beat); end
    n_cmp++; if (obs_busy_tail !== 2) begin n_fail++; $display("FAIL nostall_busy_tail: got %0d want 2", obs_busy_tail); end
    n_cmp++; if (obs_req_extra !== 0) begin n_fail++; $display("FAIL nostall_req_extra: got %0d want 0", obs_req_extra); end
    n_cmp++; if (obs_rep_leak !== 0) begin n_fail++; $display("FAIL nostall_rep_leak: got %0d want 0", obs_rep_leak); end
    for (int i = 0; i < NB; i++) begin
      w = (i < got_q.size()) ? got_q[i] : 64'hx;
      n_cmp++; if (w !== (64'h1111_0000_0000_0000 | 64'(i))) begin n_fail++; $display("FAIL nostall_word%0d: got %h want %h", i, w, 64'h1111_0000_0000_0000 | 64'(i)); end
    end
  endtask

  task automatic test_stall_gaps();
    logic [63:0] w;
    run_refill(32'h0000_1234, 3, 0, 1, -1, 0, -1, 0);
    n_cmp++; if (obs_timeout) begin n_fail++; $display("FAIL gaps_timeout: got 1 want 0"); end
    n_cmp++; if (obs_last_beat - obs_first_beat + 1 !== NB + (NB - 1) * 3) begin n_fail++; $display("FAIL gaps_fill_span: got %0d want %0d", obs_last_beat - obs_first_beat + 1, NB + (NB - 1) * 3); end
    n_cmp++; if (obs_grant !== NB) begin n_fail++; $display("FAIL gaps_grant_len: got %0d want %0d", obs_grant, NB); end
    n_cmp++; if (!obs_contig) begin n_fail++; $display("FAIL gaps_contig: got 0 want 1"); end
    n_cmp++; if (obs_busy_tail !== 2) begin n_fail++; $display("FAIL gaps_busy_tail: got %0d want 2", obs_busy_tail); end
    for (int i = 0; i < NB; i++) begin
      w = (i < got_q.size()) ? got_q[i] : 64'hx;
      n_cmp++; if (w !== (64'h1111_0000_0000_0000 | 64'(i))) begin n_fail++; $display("FAIL gaps_word%0d: got %h want %h", i, w, 64'h1111_0000_0000_0000 | 64'(i)); end
    end
  endtask

  task automatic test_flush_fetch();
    logic [63:0] w;
    run_refill(32'h0000_1234, 0, 0, 1, 4, 0, -1, 0);
    n_cmp++; if (obs_timeout) begin n_fail++; $display("FAIL flushf_timeout: got 1 want 0"); end
    n_cmp++; if (obs_grant !== 0) begin n_fail++; $display("FAIL flushf_grant: got %0d want 0", obs_grant); end
    n_cmp++; if (obs_beats !== NB) begin n_fail++; $display("FAIL flushf_req_beats: got %0d want %0d", obs_beats, NB); end
    n_cmp++; if (obs_req_extra !== 0) begin n_fail++; $display("FAIL flushf_req_extra: got %0d want 0", obs_req_extra); end
    run_refill(32'h0000_0040, 0, 0, 0, -1, 0, -1, 0);
    n_cmp++; if (obs_addr !== 32'h0000_0040) begin n_fail++; $display("FAIL flushf_next_addr: got %h want 00000040", obs_addr); end
    n_cmp++; if (obs_grant !== NB) begin n_fail++; $display("FAIL flushf_next_grant: got %0d want %0d", obs_grant, NB); end
    for (int i = 0; i < NB; i++) begin
      w = (i < got_q.size()) ? got_q[i] : 64'hx;
      n_cmp++; if (w !== sent_q[i]) begin n_fail++; $display("FAIL flushf_next_word%0d: got %h want %h", i, w, sent_q[i]); end
    end
  endtask

  task automatic test_flush_stream();
    logic [63:0] w;
    run_refill(32'h0000_2468, 0, 0, 0, -1, 1, -1, 0);
    n_cmp++; if (obs_grant !== NB) begin n_fail++; $display("FAIL flushs_grant_len: got %0d want %0d", obs_grant, NB); end
    n_cmp++; if (!obs_contig) begin n_fail++; $display("FAIL flushs_contig: got 0 want 1"); end
    n_cmp++; if (obs_busy_tail !== 2) begin n_fail++; $display("FAIL flushs_busy_tail: got %0d want 2", obs_busy_tail); end
    for (int i = 0; i < NB; i++) begin
      w = (i < got_q.size()) ? got_q[i] : 64'hx;
      n_cmp++; if (w !== sent_q[i]) begin n_fail++; $display("FAIL flushs_word%0d: got %h want %h", i, w, sent_q[i]); end
    end
  endtask

  task automatic test_reset_stream();
    logic [63:0] w;
    run_refill(32'h0000_1234, 0, 0, 1, -1, 0, 4, 0);
    n_cmp++; if (!obs_reset_hit) begin n_fail++; $display("FAIL rststream_reached: got 0 want 1"); end
    n_cmp++; if (obs_post_grant !== 1'b0) begin n_fail++; $display("FAIL rststream_grant: got %b want 0", obs_post_grant); end
    n_cmp++; if (obs_post_req !== 1'b0) begin n_fail++; $display("FAIL rststream_req: got %b want 0", obs_post_req); end
    n_cmp++; if (obs_post_busy !== 1'b0) begin n_fail++; $display("FAIL rststream_busy: got %b want 0", obs_post_busy); end
    run_refill(32'h0000_5678, 1, 0, 0, -1, 0, -1, 0);
    n_cmp++; if (obs_addr !== 32'h0000_5640) begin n_fail++; $display("FAIL rststream_next_addr: got %h want 00005640", obs_addr); end
    n_cmp++; if (obs_grant !== NB) begin n_fail++; $display("FAIL rststream_next_grant: got %0d want %0d", obs_grant, NB); end
    for (int i = 0; i < NB; i++) begin
      w = (i < got_q.size()) ? got_q[i] : 64'hx;
      n_cmp++; if (w !== sent_q[i]) begin n_fail++; $display("FAIL rststream_word%0d: got %h want %h", i, w, sent_q[i]); end
    end
  endtask

  task automatic test_miss_held();
    logic [63:0] w;
    int idle_busy, idle_req;
    for (int r = 0; r < 2; r++) begin
      run_refill(32'h0000_3000 + 32'(r * 'h1c4), 0, 1, 0, -1, 0, -1, 1);
      n_cmp++; if (obs_addr !== ((32'h0000_3000 + 32'(r * 'h1c4)) & ~32'(B - 1))) begin n_fail++; $display("FAIL held%0d_addr: got %h want %h", r, obs_addr, (32'h0000_3000 + 32'(r * 'h1c4)) & ~32'(B - 1)); end
      n_cmp++; if (obs_busy_tail !== 2) begin n_fail++; $display("FAIL held%0d_busy_tail: got %0d want 2", r, obs_busy_tail); end
      n_cmp++; if (obs_beats !== NB || obs_req_extra !== 0) begin n_fail++; $display("FAIL held%0d_burst: got %0d beats %0d extra want %0d beats 0 extra", r, obs_beats, obs_req_extra, NB); end
      for (int i = 0; i < NB; i++) begin
        w = (i < got_q.size()) ? got_q[i] : 64'hx;
        n_cmp++; if (w !== sent_q[i]) begin n_fail++; $display("FAIL held%0d_word%0d: got %h want %h", r, i, w, sent_q[i]); end
      end
    end
    ic_miss = 1'b0;
    idle_busy = 0;
    idle_req = 0;
    for (int c = 0; c < 12; c++) begin
      l2_valid = 1'($urandom_range(0, 1));
      l2_data = {$urandom(), $urandom()};
      @(negedge clk);
      if (busy) idle_busy++;
      if (l2_req) idle_req++;
    end
    l2_valid = 1'b0;
    n_cmp++; if (idle_busy !== 0) begin n_fail++; $display("FAIL idle_noise_busy: got %0d want 0", idle_busy); end
    n_cmp++; if (idle_req !== 0) begin n_fail++; $display("FAIL idle_noise_req: got %0d want 0", idle_req); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [63:0] w;
    for (int r = 0; r < 6; r++) begin
      a = $urandom();
      run_refill(a, 0, 1, 0, -1, 0, -1, 0);
      n_cmp++; if (obs_timeout) begin n_fail++; $display("FAIL rand%0d_timeout: got 1 want 0", r); end
      n_cmp++; if (obs_addr !== (a & ~32'(B - 1))) begin n_fail++; $display("FAIL rand%0d_addr: got %h want %h", r, obs_addr, a & ~32'(B - 1)); end
      n_cmp++; if (obs_grant !== NB || !obs_contig) begin n_fail++; $display("FAIL rand%0d_grant: got %0d contig %0d want %0d contig 1", r, obs_grant, obs_contig, NB); end
      n_cmp++; if (obs_busy_tail !== 2) begin n_fail++; $display("FAIL rand%0d_busy_tail: got %0d want 2", r, obs_busy_tail); end
      for (int i = 0; i < NB; i++) begin
        w = (i < got_q.size()) ? got_q[i] : 64'hx;
        n_cmp++; if (w !== sent_q[i]) begin n_fail++; $display("FAIL rand%0d_word%0d: got %h want %h", r, i, w, sent_q[i]); end
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; ic_miss = 1'b0; flush = 1'b0; l2_valid = 1'b0; l2_data = '0; miss_addr = '0;
    @(negedge clk);
    do_reset();
    test_reset();
    test_no_stall();
    test_stall_gaps();
    test_flush_fetch();
    test_flush_stream();
    test_reset_stream();
    test_miss_held();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
